// File: rtl/onchip_mem_arbiter.sv
// On-chip frame memory arbiter: shares one single-port 32-bit memory between the
// CPU data master and a sequential video scan-out stream with a small video FIFO.
module onchip_mem_arbiter #(
    parameter int unsigned ADDR_W = 17,
    parameter int unsigned DEPTH  = 76800,
    parameter int unsigned FIFO_D = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    // CPU (Avalon-MM slave side)
    input  logic [ADDR_W-1:0] cpu_address,
    input  logic              cpu_read,
    input  logic              cpu_write,
    input  logic [3:0]        cpu_byteenable,
    input  logic [31:0]       cpu_writedata,
    output logic              cpu_waitrequest,
    output logic [31:0]       cpu_readdata,
    output logic              cpu_readdatavalid,
    // Video scan-out stream
    input  logic              vid_start,
    input  logic              vid_abort,
    input  logic              vid_ready,
    output logic              vid_valid,
    output logic [31:0]       vid_data,
    output logic              vid_frame_done,
    // Memory
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic [3:0]        mem_byteenable,
    output logic [31:0]       mem_writedata,
    input  logic [31:0]       mem_readdata
);

    localparam int unsigned PtrW = $clog2(FIFO_D);
    localparam int unsigned CntW = PtrW + 1;
    localparam int unsigned OccW = CntW + 1;
    localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(DEPTH - 1);
    localparam logic [OccW-1:0]   OccMax   = OccW'(FIFO_D);

    typedef enum logic [1:0] {StIdle, StStream, StDrain} vid_state_e;

    vid_state_e        vid_state_q, vid_state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [31:0]       fifo_q [FIFO_D];
    logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]   fifo_cnt_q;
    logic              vid_inflight_q;
    logic              cpu_tag_q;
    logic              cpu_oor_q;
    // Low while in reset and for the first cycle after release; holds off the CPU.
    logic              active_q;

    logic [OccW-1:0]   occ;
    logic              video_urgent, video_room, video_want;
    logic              cpu_req, cpu_oor;
    logic              vid_grant, cpu_grant;
    logic              fifo_push, fifo_pop;

    // Arbitration, decided from registered occupancy and the live CPU request
    always_comb begin
        occ          = OccW'(fifo_cnt_q) + OccW'(vid_inflight_q);
        video_urgent = occ <= OccW'(1);
        video_room   = occ < OccMax;
        cpu_req      = active_q & (cpu_read | cpu_write);
        cpu_oor      = 32'(cpu_address) >= DEPTH;
        vid_grant    = video_want & (video_urgent | ~cpu_req);
        cpu_grant    = cpu_req & ~vid_grant;
    end

    // Video FSM state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vid_state_q <= StIdle;
        end else begin
            vid_state_q <= vid_state_d;
        end
    end

    // Video FSM next state; abort overrides everything including a concurrent start
    always_comb begin
        vid_state_d = vid_state_q;
        unique case (vid_state_q)
            StIdle:   if (vid_start) vid_state_d = StStream;
            StStream: if (vid_grant && ptr_q == LastAddr) vid_state_d = StDrain;
            StDrain:  if (vid_frame_done) vid_state_d = StIdle;
            default:  vid_state_d = StIdle;
        endcase
        if (vid_abort) vid_state_d = StIdle;
    end

    // Video FSM outputs
    always_comb begin
        video_want     = (vid_state_q == StStream) & video_room;
        vid_frame_done = (vid_state_q == StDrain) & (fifo_cnt_q == '0) & ~vid_inflight_q;
    end

    // Scan pointer next value
    always_comb begin
        ptr_d = ptr_q;
        if (vid_abort || (vid_state_q == StIdle && vid_start)) begin
            ptr_d = '0;
        end else if (vid_grant) begin
            ptr_d = ptr_q + ADDR_W'(1);
        end
    end

    // Pointer, read tags and the post-reset enable
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr_q          <= '0;
            vid_inflight_q <= 1'b0;
            cpu_tag_q      <= 1'b0;
            cpu_oor_q      <= 1'b0;
            active_q       <= 1'b0;
        end else begin
            ptr_q          <= ptr_d;
            // A read issued in the abort cycle is orphaned rather than tagged
            vid_inflight_q <= vid_grant & ~vid_abort;
            cpu_tag_q      <= cpu_grant & cpu_read & ~cpu_write;
            cpu_oor_q      <= cpu_grant & cpu_oor;
            active_q       <= 1'b1;
        end
    end

    // Video FIFO control; a returning read during abort is dropped with the flush
    always_comb begin
        fifo_push = vid_inflight_q & ~vid_abort;
        fifo_pop  = vid_valid & vid_ready;
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_cnt_q <= '0;
        end else if (vid_abort) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_cnt_q <= '0;
        end else begin
            if (fifo_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
            if (fifo_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
            fifo_cnt_q <= fifo_cnt_q + CntW'(fifo_push) - CntW'(fifo_pop);
        end
    end

    // FIFO storage; contents are masked by vid_valid so no reset is needed
    always_ff @(posedge clk) begin
        if (fifo_push) fifo_q[wr_ptr_q] <= mem_readdata;
    end

    // Memory command, CPU handshake and stream outputs
    always_comb begin
        mem_address    = '0;
        mem_chipselect = 1'b0;
        mem_write      = 1'b0;
        mem_byteenable = 4'h0;
        mem_writedata  = 32'h0;
        if (vid_grant) begin
            mem_address    = ptr_q;
            mem_chipselect = 1'b1;
            mem_byteenable = 4'hF;
        end else if (cpu_grant && !cpu_oor) begin
            mem_address    = cpu_address;
            mem_chipselect = 1'b1;
            mem_write      = cpu_write;
            mem_byteenable = cpu_write ? cpu_byteenable : 4'hF;
            mem_writedata  = cpu_write ? cpu_writedata : 32'h0;
        end

        cpu_waitrequest   = ~active_q | ((cpu_read | cpu_write) & ~cpu_grant);
        cpu_readdatavalid = cpu_tag_q;
        cpu_readdata      = (cpu_tag_q && !cpu_oor_q) ? mem_readdata : 32'h0;

        vid_valid = fifo_cnt_q != '0;
        vid_data  = vid_valid ? fifo_q[rd_ptr_q] : 32'h0;
    end

endmodule
